// File: rtl/mac_tx_arbiter_pkg.sv
// mac_pkg: shared definitions for the MAC transmit arbiter.
//   - EtherType constants for the two frame sources.
//   - Bus widths used by the arbiter interface.
//   - Channel select and arbiter state enums.
package mac_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;

    localparam int TYPE_W = 16;
    localparam int LEN_W  = 16;
    localparam int DATA_W = 8;

    // Channel identity doubles as the round-robin pointer encoding.
    typedef enum logic {
        CH_IPV4 = 1'b0,
        CH_ARP  = 1'b1
    } ch_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_PASS  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// mac_tx_arbiter_if: bundles the two frame-source channels and the MAC-side
// handshake/stream of the transmit arbiter.
//   ch0/ch1 : req_valid/req_ready handshake, type, len, data/valid/last beat
//   MAC     : o_mac_req/i_mac_ready handshake, send_type/len/data/valid/last
//   status  : o_err_len, o_err_timeout, o_busy
// Modports: slave = the arbiter, master = whoever drives the sources and MAC.
interface mac_tx_arbiter_if;
    import mac_pkg::*;

    logic              i_ch0_req_valid;
    logic              o_ch0_req_ready;
    logic [TYPE_W-1:0] i_ch0_type;
    logic [LEN_W-1:0]  i_ch0_len;
    logic [DATA_W-1:0] i_ch0_data;
    logic              i_ch0_valid;
    logic              i_ch0_last;

    logic              i_ch1_req_valid;
    logic              o_ch1_req_ready;
    logic [TYPE_W-1:0] i_ch1_type;
    logic [LEN_W-1:0]  i_ch1_len;
    logic [DATA_W-1:0] i_ch1_data;
    logic              i_ch1_valid;
    logic              i_ch1_last;

    logic              o_mac_req;
    logic              i_mac_ready;
    logic [TYPE_W-1:0] o_send_type;
    logic [LEN_W-1:0]  o_send_len;
    logic [DATA_W-1:0] o_send_data;
    logic              o_send_valid;
    logic              o_send_last;
    logic              o_err_len;
    logic              o_err_timeout;
    logic              o_busy;

    modport slave (
        input  i_ch0_req_valid, i_ch0_type, i_ch0_len, i_ch0_data, i_ch0_valid, i_ch0_last,
        input  i_ch1_req_valid, i_ch1_type, i_ch1_len, i_ch1_data, i_ch1_valid, i_ch1_last,
        input  i_mac_ready,
        output o_ch0_req_ready, o_ch1_req_ready, o_mac_req,
        output o_send_type, o_send_len, o_send_data, o_send_valid, o_send_last,
        output o_err_len, o_err_timeout, o_busy
    );

    modport master (
        output i_ch0_req_valid, i_ch0_type, i_ch0_len, i_ch0_data, i_ch0_valid, i_ch0_last,
        output i_ch1_req_valid, i_ch1_type, i_ch1_len, i_ch1_data, i_ch1_valid, i_ch1_last,
        output i_mac_ready,
        input  o_ch0_req_ready, o_ch1_req_ready, o_mac_req,
        input  o_send_type, o_send_len, o_send_data, o_send_valid, o_send_last,
        input  o_err_len, o_err_timeout, o_busy
    );

endinterface

// File: rtl/mac_arb_pick.sv
// mac_arb_pick: combinational winner select for the transmit arbiter.
//   req0_i/req1_i : pending requests of ch0 (IPv4) / ch1 (ARP)
//   rr_i          : round-robin pointer, channel favoured on a tie
//   any_o         : at least one request pending
//   winner_o      : selected channel (meaningful only when any_o)
// Build option: MAC_ARB_ARP_PRIORITY_EN selects strict ARP priority and
// ignores the round-robin pointer.
module mac_arb_pick
    import mac_pkg::*;
(
    input  logic    req0_i,
    input  logic    req1_i,
    input  ch_sel_t rr_i,
    output logic    any_o,
    output ch_sel_t winner_o
);

    assign any_o = req0_i | req1_i;

`ifdef MAC_ARB_ARP_PRIORITY_EN
    // ARP wins whenever it asks; the pointer has no say.
    logic unused_rr;
    assign unused_rr = rr_i;
    assign winner_o  = req1_i ? CH_ARP : CH_IPV4;
`else
    // Tie goes to the pointer, otherwise to whichever channel is asking.
    assign winner_o = (req0_i && req1_i) ? rr_i : (req1_i ? CH_ARP : CH_IPV4);
`endif

endmodule

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: shares one MAC transmit engine between ch0 (IPv4/UDP) and
// ch1 (ARP). Arbitrates per frame, handshakes with the MAC, forwards the
// winner's type/len and byte stream through one register stage, enforces an
// inter-frame gap, and flags length mismatches and mid-frame stalls.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : channel request/stream inputs, MAC handshake and send
//                  outputs, error pulses and busy flag
// Parameters: P_IFG idle cycles in GAP (>=1), P_TIMEOUT stall limit in PASS.
// Build option: MAC_ARB_ARP_PRIORITY_EN (strict ARP priority, see mac_arb_pick).
module mac_tx_arbiter
    import mac_pkg::*;
#(
    parameter int P_IFG     = 12,
    parameter int P_TIMEOUT = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mac_tx_arbiter_if.slave  bus
);

    localparam int GW = $clog2(P_IFG + 1);
    localparam int TW = $clog2(P_TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    ch_sel_t           winner_q, winner_d;
    ch_sel_t           rr_q, rr_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [TW-1:0]     stall_q, stall_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              err_len_q, err_len_d;
    logic              err_to_q, err_to_d;

    logic              mac_req, ready0, ready1;
    logic              pick_any;
    ch_sel_t           pick_win;

    mac_arb_pick u_pick (
        .req0_i   (bus.i_ch0_req_valid),
        .req1_i   (bus.i_ch1_req_valid),
        .rr_i     (rr_q),
        .any_o    (pick_any),
        .winner_o (pick_win)
    );

    // Only the granted channel's beat lane is looked at in PASS.
    logic              w_valid, w_last;
    logic [DATA_W-1:0] w_data;
    assign w_valid = (winner_q == CH_ARP) ? bus.i_ch1_valid : bus.i_ch0_valid;
    assign w_last  = (winner_q == CH_ARP) ? bus.i_ch1_last  : bus.i_ch0_last;
    assign w_data  = (winner_q == CH_ARP) ? bus.i_ch1_data  : bus.i_ch0_data;

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        rr_d      = rr_q;
        beat_d    = beat_q;
        stall_d   = stall_q;
        gap_d     = gap_q;
        type_d    = type_q;
        len_d     = len_q;
        data_d    = '0;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        err_len_d = 1'b0;
        err_to_d  = 1'b0;
        mac_req   = 1'b0;
        ready0    = 1'b0;
        ready1    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    // Latch type/len on entry so they are valid for the whole GRANT.
                    winner_d = pick_win;
                    type_d   = (pick_win == CH_ARP) ? bus.i_ch1_type : bus.i_ch0_type;
                    len_d    = (pick_win == CH_ARP) ? bus.i_ch1_len  : bus.i_ch0_len;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                mac_req = 1'b1;
                if (bus.i_mac_ready) begin
                    ready0  = (winner_q == CH_IPV4);
                    ready1  = (winner_q == CH_ARP);
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                if (w_valid) begin
                    data_d  = w_data;
                    valid_d = 1'b1;
                    last_d  = w_last;
                    beat_d  = beat_q + 16'd1;
                    stall_d = '0;
                    // A last beat takes precedence over a coincident stall expiry.
                    if (w_last) begin
                        err_len_d = ((beat_q + 16'd1) != len_q);
                        rr_d      = (winner_q == CH_ARP) ? CH_IPV4 : CH_ARP;
                        gap_d     = '0;
                        state_d   = ST_GAP;
                    end
                end else if (stall_q == TW'(P_TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    rr_d     = (rr_q == CH_ARP) ? CH_IPV4 : CH_ARP;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                end else begin
                    stall_d = stall_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(P_IFG - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            winner_q  <= CH_IPV4;
            rr_q      <= CH_IPV4;
            beat_q    <= '0;
            stall_q   <= '0;
            gap_q     <= '0;
            type_q    <= '0;
            len_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            rr_q      <= rr_d;
            beat_q    <= beat_d;
            stall_q   <= stall_d;
            gap_q     <= gap_d;
            type_q    <= type_d;
            len_q     <= len_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
        end
    end

    assign bus.o_mac_req       = mac_req;
    assign bus.o_ch0_req_ready = ready0;
    assign bus.o_ch1_req_ready = ready1;
    assign bus.o_send_type     = type_q;
    assign bus.o_send_len      = len_q;
    assign bus.o_send_data     = data_q;
    assign bus.o_send_valid    = valid_q;
    assign bus.o_send_last     = last_q;
    assign bus.o_err_len       = err_len_q;
    assign bus.o_err_timeout   = err_to_q;
    assign bus.o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: directed stimulus with a scoreboard. Drivers push the
// expected grants, forwarded beats and timeout pulses into queues; a monitor
// on the falling clock edge pops and compares whenever the DUT shows one.
module tb_mac_tx_arbiter;
    import mac_pkg::*;

    localparam int IFG    = 12;
    localparam int TO     = 1024;
    localparam int BUDGET = 3000;

`ifdef MAC_ARB_ARP_PRIORITY_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_tx_arbiter_if bus ();

    mac_tx_arbiter #(.P_IFG(IFG), .P_TIMEOUT(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic        err;
        logic [15:0] typ;
        logic [15:0] len;
    } beat_t;

    typedef struct packed {
        int ch;
        int gap;
    } grant_t;

    beat_t  beat_q[$];
    grant_t grant_q[$];
    int     to_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rise_cyc = 0;
    int end_cyc  = 0;
    int last_beat_cyc = 0;
    logic prev_req = 1'b0;
    logic [15:0] ch_len [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_mac_req"},    int'(bus.o_mac_req), 0);
        chk({tag, "_ready0"},     int'(bus.o_ch0_req_ready), 0);
        chk({tag, "_ready1"},     int'(bus.o_ch1_req_ready), 0);
        chk({tag, "_send_type"},  int'(bus.o_send_type), 0);
        chk({tag, "_send_len"},   int'(bus.o_send_len), 0);
        chk({tag, "_send_data"},  int'(bus.o_send_data), 0);
        chk({tag, "_send_valid"}, int'(bus.o_send_valid), 0);
        chk({tag, "_send_last"},  int'(bus.o_send_last), 0);
        chk({tag, "_err_len"},    int'(bus.o_err_len), 0);
        chk({tag, "_err_to"},     int'(bus.o_err_timeout), 0);
        chk({tag, "_busy"},       int'(bus.o_busy), 0);
    endtask

    task automatic arm(input int ch, input logic [15:0] len);
        ch_len[ch] = len;
        if (ch == 0) begin
            bus.i_ch0_req_valid = 1'b1;
            bus.i_ch0_type      = ETH_TYPE_IPV4;
            bus.i_ch0_len       = len;
        end else begin
            bus.i_ch1_req_valid = 1'b1;
            bus.i_ch1_type      = ETH_TYPE_ARP;
            bus.i_ch1_len       = len;
        end
    endtask

    task automatic clear_beats();
        bus.i_ch0_valid = 1'b0; bus.i_ch0_last = 1'b0; bus.i_ch0_data = 8'h00;
        bus.i_ch1_valid = 1'b0; bus.i_ch1_last = 1'b0; bus.i_ch1_data = 8'h00;
    endtask

    // mode 0: finish with last; 1: stall until timeout; 2: stop without last
    task automatic serve(input int ch, input int rdy, input int gap,
                         input int nb, input int mode, input bit noise);
        bit ok = 1'b0;
        logic [7:0] d;
        logic lst;
        beat_t b;
        grant_t g;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            step();
            if (bus.o_mac_req) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL mac_req_wait got=no_request exp=request_for_ch%0d", ch);
            return;
        end
        g.ch = ch; g.gap = gap;
        grant_q.push_back(g);
        repeat (rdy) step();
        bus.i_mac_ready = 1'b1;
        step();
        bus.i_mac_ready = 1'b0;
        if (ch == 0) bus.i_ch0_req_valid = 1'b0;
        else         bus.i_ch1_req_valid = 1'b0;
        for (int k = 0; k < nb; k++) begin
            d   = 8'(ch * 16 + k + 1);
            lst = (mode == 0) && (k == nb - 1);
            if (ch == 0) begin
                bus.i_ch0_valid = 1'b1; bus.i_ch0_data = d; bus.i_ch0_last = lst;
                if (noise) begin bus.i_ch1_valid = 1'b1; bus.i_ch1_data = 8'hEE; bus.i_ch1_last = 1'b1; end
            end else begin
                bus.i_ch1_valid = 1'b1; bus.i_ch1_data = d; bus.i_ch1_last = lst;
                if (noise) begin bus.i_ch0_valid = 1'b1; bus.i_ch0_data = 8'hEE; bus.i_ch0_last = 1'b1; end
            end
            b.data = d;
            b.last = lst;
            b.err  = lst && (16'(nb) != ch_len[ch]);
            b.typ  = (ch == 0) ? ETH_TYPE_IPV4 : ETH_TYPE_ARP;
            b.len  = ch_len[ch];
            beat_q.push_back(b);
            step();
        end
        clear_beats();
        if (mode == 1) to_q.push_back(TO);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Monitor: compares every DUT-presented event against the scoreboard.
    initial begin
        beat_t  e;
        grant_t g;
        int     got_ch;
        int     exp_to;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (bus.o_mac_req && !prev_req) rise_cyc = cyc;
                prev_req = bus.o_mac_req;

                if (bus.o_ch0_req_ready || bus.o_ch1_req_ready) begin
                    got_ch = bus.o_ch1_req_ready ? 1 : 0;
                    if (grant_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL grant_unexpected got_ch=%0d exp=none", got_ch);
                    end else begin
                        g = grant_q.pop_front();
                        chk("grant_ch", got_ch, g.ch);
                        chk("grant_onehot", int'(bus.o_ch0_req_ready & bus.o_ch1_req_ready), 0);
                        if (g.gap >= 0) chk("gap_cycles", rise_cyc - end_cyc, g.gap);
                    end
                end

                if (bus.o_send_valid) begin
                    last_beat_cyc = cyc;
                    if (bus.o_send_last) end_cyc = cyc;
                    total++;
                    if (beat_q.size() == 0) begin
                        bad++;
                        $display("FAIL beat_unexpected got data=%h last=%b exp=none",
                                 bus.o_send_data, bus.o_send_last);
                    end else begin
                        e = beat_q.pop_front();
                        if (bus.o_send_data !== e.data || bus.o_send_last !== e.last ||
                            bus.o_err_len !== e.err || bus.o_send_type !== e.typ ||
                            bus.o_send_len !== e.len) begin
                            bad++;
                            $display("FAIL beat got data=%h last=%b err=%b type=%h len=%0d exp data=%h last=%b err=%b type=%h len=%0d",
                                     bus.o_send_data, bus.o_send_last, bus.o_err_len,
                                     bus.o_send_type, bus.o_send_len,
                                     e.data, e.last, e.err, e.typ, e.len);
                        end
                    end
                end else if (bus.o_err_len || bus.o_send_last) begin
                    total++; bad++;
                    $display("FAIL stray_flag got err_len=%b last=%b exp=0 without valid",
                             bus.o_err_len, bus.o_send_last);
                end

                if (bus.o_err_timeout) begin
                    end_cyc = cyc;
                    if (to_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL timeout_unexpected got=1 exp=0");
                    end else begin
                        exp_to = to_q.pop_front();
                        chk("timeout_delay", cyc - last_beat_cyc, exp_to);
                    end
                end
            end
        end
    end

    initial begin
        bus.i_ch0_req_valid = 1'b0; bus.i_ch0_type = '0; bus.i_ch0_len = '0;
        bus.i_ch1_req_valid = 1'b0; bus.i_ch1_type = '0; bus.i_ch1_len = '0;
        bus.i_mac_ready     = 1'b0;
        clear_beats();

        // Reset state
        repeat (3) step();
        check_idle("reset");
        rst = 1'b0;

        // ch0 alone, ready three cycles after the request
        arm(0, 16'd2);
        serve(0, 3, -1, 2, 0, 1'b0);
        repeat (IFG + 3) step();
        pulse_reset();

        // Both requesting from reset, two rounds
        for (int r = 0; r < 2; r++) begin
            arm(0, 16'd2);
            arm(1, 16'd2);
            serve(FIRST,     1, (r == 0) ? -1 : IFG + 1, 2, 0, 1'b0);
            serve(1 - FIRST, 0, IFG + 1,                 2, 0, 1'b0);
        end

        // ch1 declares 4 bytes but sends 3; ch0 lane noise must be ignored
        arm(1, 16'd4);
        serve(1, 2, IFG + 1, 3, 0, 1'b1);

        // ch0 stalls after one beat; ch1 waits and is served after the gap
        arm(0, 16'd5);
        serve(0, 1, IFG + 1, 1, 1, 1'b0);
        arm(1, 16'd2);
        serve(1, 0, IFG + 1, 2, 0, 1'b0);

        // Reset mid-PASS, then a fresh request
        arm(0, 16'd4);
        serve(0, 0, IFG + 1, 2, 2, 1'b0);
        step();
        pulse_reset();
        check_idle("midrst");
        arm(1, 16'd2);
        serve(1, 0, -1, 2, 0, 1'b0);

        repeat (IFG + 5) step();
        chk("beats_pending",   beat_q.size(),  0);
        chk("grants_pending",  grant_q.size(), 0);
        chk("timeout_pending", to_q.size(),    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
